// File: rtl/approx_mult_error_monitor_if.sv
// Sample stream from an approximate multiplier under test: operands,
// approximate product and a valid/ready handshake.
interface approx_mult_error_monitor_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [2*WIDTH-1:0]   p_apprx;

    modport master (output in_valid, a, b, p_apprx, input in_ready);
    modport slave  (input in_valid, a, b, p_apprx, output in_ready);
endinterface

// File: rtl/approx_mult_error_monitor.sv
// Error-statistics monitor for an N-bit approximate multiplier.
// Forms the exact product, compares it with the streamed approximate
// product and accumulates error count, sum |ED| and max |ED| over a run
// of num_samples samples. Two-stage pipeline: exact product, then |ED|.
// Optional macro APPROX_MON_SIGNED_SUM_EN adds a saturating signed sum of
// (exact - p_apprx) for bias measurement.
module approx_mult_error_monitor #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 24,
    parameter int SUM_W = 2*WIDTH+CNT_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [CNT_W-1:0]            num_samples,
    approx_mult_error_monitor_if.slave  smp,
    output logic                        busy,
    output logic                        done,
    output logic [CNT_W-1:0]            sample_count,
    output logic [CNT_W-1:0]            err_count,
    output logic [SUM_W-1:0]            sum_ed_abs,
    output logic [2*WIDTH-1:0]          max_ed
`ifdef APPROX_MON_SIGNED_SUM_EN
    ,
    output logic signed [SUM_W:0]       sum_ed_signed
`endif
);
    localparam int PW = 2*WIDTH;
    // Adder wide enough that neither operand nor the carry is lost before saturation.
    localparam int AW = ((SUM_W > PW) ? SUM_W : PW) + 1;
    localparam logic [AW-1:0] SUM_MAX = AW'({SUM_W{1'b1}});

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   n_lat;
    logic               ready_q;
    logic               accept;
    logic               clr;
    logic [2:1]         vld_pipe;
    logic [PW-1:0]      exact1;
    logic [PW-1:0]      papx1;
    logic [PW:0]        diff;
    logic [PW:0]        neg_diff;
    logic [PW-1:0]      abs2;
    logic               mis2;
    logic [AW-1:0]      sum_nxt;

    assign smp.in_ready = ready_q;
    assign accept       = smp.in_valid & ready_q;
    assign clr          = start && (state == IDLE);

    // Signed difference one bit wider than the product, so the sign is never lost.
    assign diff     = {1'b0, exact1} - {1'b0, papx1};
    assign neg_diff = -diff;
    assign sum_nxt  = AW'(sum_ed_abs) + AW'(abs2);

`ifdef APPROX_MON_SIGNED_SUM_EN
    localparam int SW = ((SUM_W > PW) ? SUM_W : PW) + 2;
    localparam logic signed [SW-1:0] SMAX = $signed({{(SW-SUM_W){1'b0}}, {SUM_W{1'b1}}});
    localparam logic signed [SW-1:0] SMIN = $signed({{(SW-SUM_W){1'b1}}, {SUM_W{1'b0}}});
    logic signed [PW:0]     sed2;
    logic signed [SW-1:0]   ssum_nxt;
    assign ssum_nxt = $signed({{(SW-SUM_W-1){sum_ed_signed[SUM_W]}}, sum_ed_signed})
                    + $signed({{(SW-PW-1){sed2[PW]}}, sed2});
`endif

    // Run control: IDLE -> RUN -> DRAIN -> DONE, all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            n_lat   <= '0;
            ready_q <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    n_lat <= num_samples;
                    if (num_samples != '0) begin
                        state   <= RUN;
                        ready_q <= 1'b1;
                        busy    <= 1'b1;
                    end else begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                RUN: if (accept && (sample_count + CNT_W'(1) == n_lat)) begin
                    ready_q <= 1'b0;
                    state   <= DRAIN;
                end
                // Stage 1 empty means stage 2 retires its last sample at this edge.
                DRAIN: if (!vld_pipe[1]) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Two-stage datapath: exact product, then |ED| and mismatch flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            exact1   <= '0;
            papx1    <= '0;
            abs2     <= '0;
            mis2     <= 1'b0;
`ifdef APPROX_MON_SIGNED_SUM_EN
            sed2     <= '0;
`endif
        end else begin
            vld_pipe[1] <= accept;
            vld_pipe[2] <= vld_pipe[1];
            exact1      <= PW'(smp.a) * PW'(smp.b);
            papx1       <= smp.p_apprx;
            abs2        <= diff[PW] ? neg_diff[PW-1:0] : diff[PW-1:0];
            mis2        <= (exact1 != papx1);
`ifdef APPROX_MON_SIGNED_SUM_EN
            sed2        <= $signed(diff);
`endif
        end
    end

    // Statistics: cleared on accepted start, updated as samples leave stage 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_count  <= '0;
            err_count     <= '0;
            sum_ed_abs    <= '0;
            max_ed        <= '0;
`ifdef APPROX_MON_SIGNED_SUM_EN
            sum_ed_signed <= '0;
`endif
        end else if (clr) begin
            sample_count  <= '0;
            err_count     <= '0;
            sum_ed_abs    <= '0;
            max_ed        <= '0;
`ifdef APPROX_MON_SIGNED_SUM_EN
            sum_ed_signed <= '0;
`endif
        end else begin
            if (accept) sample_count <= sample_count + CNT_W'(1);
            if (vld_pipe[2]) begin
                if (mis2 && (err_count != '1)) err_count <= err_count + CNT_W'(1);
                if (sum_nxt > SUM_MAX) sum_ed_abs <= '1;
                else                   sum_ed_abs <= sum_nxt[SUM_W-1:0];
                if (abs2 > max_ed)     max_ed <= abs2;
`ifdef APPROX_MON_SIGNED_SUM_EN
                if (ssum_nxt > SMAX)      sum_ed_signed <= $signed({1'b0, {SUM_W{1'b1}}});
                else if (ssum_nxt < SMIN) sum_ed_signed <= $signed({1'b1, {SUM_W{1'b0}}});
                else                      sum_ed_signed <= $signed(ssum_nxt[SUM_W:0]);
`endif
            end
        end
    end
endmodule

// File: tb/tb_approx_mult_error_monitor.sv
// Bench for approx_mult_error_monitor: a list-based model of accepted
// samples checked every cycle, plus literal expectations for directed runs
// and a small-accumulator instance for saturation.
module tb_approx_mult_error_monitor;
    localparam int WIDTH = 8;
    localparam int CNT_W = 24;
    localparam int SUM_W = 2*WIDTH+CNT_W;
    localparam longint SUM_MAX = (longint'(1) << SUM_W) - 1;
    localparam longint SMAX    = (longint'(1) << SUM_W) - 1;
    localparam longint SMIN    = -(longint'(1) << SUM_W);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                   start;
    logic [CNT_W-1:0]       num_samples;
    logic                   busy, done;
    logic [CNT_W-1:0]       sample_count, err_count;
    logic [SUM_W-1:0]       sum_ed_abs;
    logic [2*WIDTH-1:0]     max_ed;
`ifdef APPROX_MON_SIGNED_SUM_EN
    logic signed [SUM_W:0]  sum_ed_signed;
`endif

    approx_mult_error_monitor_if #(.WIDTH(WIDTH)) mif ();

    approx_mult_error_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
        .smp(mif), .busy(busy), .done(done), .sample_count(sample_count),
        .err_count(err_count), .sum_ed_abs(sum_ed_abs), .max_ed(max_ed)
`ifdef APPROX_MON_SIGNED_SUM_EN
        , .sum_ed_signed(sum_ed_signed)
`endif
    );

    // Small-accumulator instance for the saturation case.
    logic               start2;
    logic [3:0]         num2;
    logic               busy2, done2;
    logic [3:0]         sc2, ec2;
    logic [7:0]         sum2;
    logic [15:0]        max2;
`ifdef APPROX_MON_SIGNED_SUM_EN
    logic signed [8:0]  ss2;
`endif

    approx_mult_error_monitor_if #(.WIDTH(WIDTH)) sif ();

    approx_mult_error_monitor #(.WIDTH(WIDTH), .CNT_W(4), .SUM_W(8)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start2), .num_samples(num2),
        .smp(sif), .busy(busy2), .done(done2), .sample_count(sc2),
        .err_count(ec2), .sum_ed_abs(sum2), .max_ed(max2)
`ifdef APPROX_MON_SIGNED_SUM_EN
        , .sum_ed_signed(ss2)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: the run is a list of accepted samples with their acceptance
    // cycle; a sample shows up in the statistics three cycles later.
    bit     m_active = 1'b0;
    int     m_n = 0, m_start = 0, m_done = 0, m_acc = 0;
    int     q_cyc[$];
    longint q_ed[$];
    int     done_pulses = 0;

    always @(negedge clk) begin
        longint e_err, e_sum, e_max, e_ss, ed, ad;
        bit     e_rdy, e_busy, e_done, idle;
        if (!rst_n) begin
            m_active = 1'b0;
            m_acc    = 0;
            q_cyc.delete();
            q_ed.delete();
        end
        e_err = 0; e_sum = 0; e_max = 0; e_ss = 0;
        foreach (q_cyc[i]) begin
            if (q_cyc[i] <= cyc - 3) begin
                ed = q_ed[i];
                ad = (ed < 0) ? -ed : ed;
                if (ed != 0) e_err++;
                e_sum += ad;
                if (ad > e_max) e_max = ad;
                e_ss += ed;
                if (e_ss > SMAX) e_ss = SMAX;
                if (e_ss < SMIN) e_ss = SMIN;
            end
        end
        if (e_sum > SUM_MAX) e_sum = SUM_MAX;
        e_rdy  = m_active && (cyc > m_start) && (m_acc < m_n);
        e_busy = m_active && (cyc > m_start) && (cyc < m_done);
        e_done = m_active && (cyc == m_done);

        chk("in_ready", longint'(mif.in_ready), longint'(e_rdy));
        chk("busy", longint'(busy), longint'(e_busy));
        chk("done", longint'(done), longint'(e_done));
        chk("sample_count", longint'(sample_count), longint'(q_cyc.size()));
        chk("err_count", longint'(err_count), e_err);
        chk("sum_ed_abs", longint'(sum_ed_abs), e_sum);
        chk("max_ed", longint'(max_ed), e_max);
`ifdef APPROX_MON_SIGNED_SUM_EN
        chk("sum_ed_signed", longint'(sum_ed_signed), e_ss);
`endif
        if (done) done_pulses++;

        if (rst_n) begin
            idle = !m_active || (cyc > m_done);
            if (start && idle) begin
                m_active = 1'b1;
                m_n      = int'(num_samples);
                m_start  = cyc;
                m_acc    = 0;
                m_done   = (m_n == 0) ? cyc + 1 : (1 << 30);
                q_cyc.delete();
                q_ed.delete();
            end else if (mif.in_valid && e_rdy) begin
                q_cyc.push_back(cyc);
                q_ed.push_back(longint'(mif.a) * longint'(mif.b) - longint'(mif.p_apprx));
                m_acc++;
                if (m_acc == m_n) m_done = cyc + 3;
            end
        end
    end

    int va[$], vb[$], vp[$];

    task automatic begin_run(input int n);
        start = 1'b1;
        num_samples = CNT_W'(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed(input int gap);
        int idx = 0;
        int guard = 0;
        while (idx < va.size() && guard < 4000) begin
            if (gap != 0 && (guard % gap) == gap - 1) begin
                mif.in_valid = 1'b0;
            end else begin
                mif.in_valid = 1'b1;
                mif.a = 8'(va[idx]);
                mif.b = 8'(vb[idx]);
                mif.p_apprx = 16'(vp[idx]);
            end
            @(negedge clk);
            if (mif.in_valid && mif.in_ready) idx++;
            @(posedge clk); #1;
            guard++;
        end
        mif.in_valid = 1'b0;
        chk("feed_complete", longint'(idx), longint'(va.size()));
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int k = 0; k < 30 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            @(posedge clk); #1;
        end
        chk("done_seen", longint'(seen), 1);
    endtask

    initial begin
        int d0, acc, last_acc, dcyc, acc2;
        bit seen2;
        start = 1'b0; num_samples = '0;
        mif.in_valid = 1'b0; mif.a = '0; mif.b = '0; mif.p_apprx = '0;
        start2 = 1'b0; num2 = '0;
        sif.in_valid = 1'b0; sif.a = '0; sif.b = '0; sif.p_apprx = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", longint'(mif.in_ready), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_sample_count", longint'(sample_count), 0);
        chk("rst_err_count", longint'(err_count), 0);
        chk("rst_sum", longint'(sum_ed_abs), 0);
        chk("rst_max", longint'(max_ed), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed errors: |ED| = 25, 0, 20, 1.
        va = '{255, 3, 10, 0}; vb = '{255, 5, 10, 7}; vp = '{65000, 15, 120, 1};
        d0 = done_pulses;
        begin_run(4);
        feed(0);
        wait_done();
        repeat (2) @(posedge clk);
        #1;
        chk("dir_count", longint'(sample_count), 4);
        chk("dir_err", longint'(err_count), 3);
        chk("dir_sum", longint'(sum_ed_abs), 46);
        chk("dir_max", longint'(max_ed), 25);
        chk("dir_done_once", longint'(done_pulses - d0), 1);
`ifdef APPROX_MON_SIGNED_SUM_EN
        chk("dir_signed", longint'(sum_ed_signed), 4);
`endif

        // Handshake: valid held for 6 cycles, stray start while busy.
        d0 = done_pulses; acc = 0; last_acc = -1; dcyc = -100;
        begin_run(3);
        mif.in_valid = 1'b1; mif.a = 8'd2; mif.b = 8'd3; mif.p_apprx = 16'd6;
        for (int k = 0; k < 10; k++) begin
            start = (k == 1);
            num_samples = (k == 1) ? CNT_W'(50) : CNT_W'(3);
            if (k == 6) mif.in_valid = 1'b0;
            @(negedge clk);
            if (mif.in_valid && mif.in_ready) begin acc++; last_acc = cyc; end
            if (done) dcyc = cyc;
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("hs_accepts", longint'(acc), 3);
        chk("hs_done_latency", longint'(dcyc - last_acc), 3);
        chk("hs_count", longint'(sample_count), 3);
        chk("hs_done_once", longint'(done_pulses - d0), 1);

        // Zero-length run.
        begin_run(0);
        @(negedge clk);
        chk("zero_done", longint'(done), 1);
        chk("zero_count", longint'(sample_count), 0);
        chk("zero_sum", longint'(sum_ed_abs), 0);
        @(posedge clk); #1;

        // Exact multiplier, 1000 random pairs with periodic valid gaps.
        va.delete(); vb.delete(); vp.delete();
        for (int i = 0; i < 1000; i++) begin
            int x, y;
            x = int'($urandom_range(0, 255));
            y = int'($urandom_range(0, 255));
            va.push_back(x); vb.push_back(y); vp.push_back(x * y);
        end
        d0 = done_pulses;
        begin_run(1000);
        feed(7);
        wait_done();
        @(posedge clk); #1;
        chk("exact_count", longint'(sample_count), 1000);
        chk("exact_err", longint'(err_count), 0);
        chk("exact_sum", longint'(sum_ed_abs), 0);
        chk("exact_max", longint'(max_ed), 0);
        chk("exact_done_once", longint'(done_pulses - d0), 1);

        // Reset mid-run after 10 of 100 samples.
        va.delete(); vb.delete(); vp.delete();
        for (int i = 0; i < 10; i++) begin
            va.push_back(1); vb.push_back(1); vp.push_back(0);
        end
        begin_run(100);
        feed(0);
        d0 = done_pulses;
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", longint'(mif.in_ready), 0);
        chk("mid_rst_busy", longint'(busy), 0);
        chk("mid_rst_done", longint'(done), 0);
        chk("mid_rst_count", longint'(sample_count), 0);
        chk("mid_rst_err", longint'(err_count), 0);
        chk("mid_rst_sum", longint'(sum_ed_abs), 0);
        chk("mid_rst_max", longint'(max_ed), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("mid_rst_no_done", longint'(done_pulses - d0), 0);

        // Saturation on the 8-bit accumulator: two samples with |ED| = 200.
        start2 = 1'b1; num2 = 4'd2;
        @(posedge clk); #1;
        start2 = 1'b0;
        sif.in_valid = 1'b1; sif.a = 8'd0; sif.b = 8'd0; sif.p_apprx = 16'd200;
        acc2 = 0; seen2 = 1'b0;
        for (int k = 0; k < 20 && !seen2; k++) begin
            @(negedge clk);
            if (sif.in_valid && sif.in_ready) acc2++;
            if (done2) seen2 = 1'b1;
            @(posedge clk); #1;
            if (acc2 == 2) sif.in_valid = 1'b0;
        end
        sif.in_valid = 1'b0;
        chk("sat_done_seen", longint'(seen2), 1);
        chk("sat_accepts", longint'(acc2), 2);
        chk("sat_count", longint'(sc2), 2);
        chk("sat_err", longint'(ec2), 2);
        chk("sat_sum", longint'(sum2), 255);
        chk("sat_max", longint'(max2), 200);
`ifdef APPROX_MON_SIGNED_SUM_EN
        chk("sat_signed", longint'(ss2), -256);
`endif

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/approx_mult_error_monitor.md
Name: approx_mult_error_monitor

Overview:
- Synthesizable, parametrised successor to the simulation-only error-statistics bench for approximate multipliers.
- Streams operand pairs plus the approximate product from a multiplier under test and forms the exact product internally.
- Accumulates hardware error statistics over a programmed sample count: error count, sum of |ED|, max |ED|.
- Sits beside any N-bit approximate multiplier, on-chip or on FPGA, for at-speed characterisation; MED, MRED and MNED are derived off-block.

Parameters:
- WIDTH, 8, operand width in bits.
- CNT_W, 24, width of the sample counter and of the error counter.
- SUM_W, 2*WIDTH+CNT_W, width of the |ED| accumulator.

Ports:
- clk  in  1  clock; all flops on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse: clear statistics and begin a run; honoured in IDLE only.
- num_samples  in  CNT_W  samples in the run; sampled on accepted start.
- in_valid  in  1  a, b, p_apprx valid.
- in_ready  out  1  monitor accepts a sample this cycle.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- p_apprx  in  2*WIDTH  approximate product for (a,b).
- busy  out  1  state is RUN or DRAIN.
- done  out  1  one-cycle pulse when final statistics are valid.
- sample_count  out  CNT_W  samples accepted this run.
- err_count  out  CNT_W  samples where exact != p_apprx.
- sum_ed_abs  out  SUM_W  sum of |exact - p_apprx|.
- max_ed  out  2*WIDTH  largest |exact - p_apprx| this run.

Behaviour:
- Reset: in_ready=0, busy=0, done=0, all counters and accumulators 0, pipeline valid bits 0, state IDLE. Assertion mid-run aborts immediately; no partial done.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 clears all statistics and latches num_samples. Next state is RUN if num_samples != 0, else DONE.
- RUN: in_ready=1 while sample_count < latched num_samples. A sample transfers when in_valid & in_ready. When the transfer that makes sample_count equal num_samples occurs, in_ready drops the next cycle and the state moves to DRAIN.
- DRAIN: waits until both pipeline stages are empty, then moves to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Statistic outputs hold their values after done until the next accepted start.
- start outside IDLE is ignored.
- Pipeline stage 1: register exact = a*b (2*WIDTH unsigned), p_apprx and a valid bit.
- Pipeline stage 2: register abs_ed = |exact - p_apprx|, computed at 2*WIDTH+1 bits then truncated (magnitude always fits 2*WIDTH), and mismatch = (exact != p_apprx).
- Accumulator update: err_count += mismatch; sum_ed_abs += abs_ed; max_ed = max(max_ed, abs_ed).
- Latency: a sample accepted in cycle t is reflected in the statistics at the edge ending cycle t+2.
- sample_count increments at acceptance.
- done asserts 3 cycles after the last acceptance: 2 pipeline cycles plus the DRAIN-to-DONE transition.
- Saturation: sum_ed_abs and err_count saturate at all-ones and never wrap.
- Back-to-back acceptance every cycle is supported; in_valid gaps only stall, they never reorder samples.

Optional Feature:
- Macro: APPROX_MON_SIGNED_SUM_EN.
- Defined: adds output sum_ed_signed (signed, SUM_W+1 bits), accumulating exact - p_apprx in two's complement and saturating at the signed min/max. It is cleared on start and on reset, with the same latency as sum_ed_abs. This enables bias (mean signed error) measurement.
- Undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-run: start with num_samples=100, drive 10 samples, pull rst_n low asynchronously -> all outputs 0 immediately, state IDLE, no done pulse.
- Exact multiplier, WIDTH=8: num_samples=1000 random pairs with p_apprx=a*b -> done once; sample_count=1000, err_count=0, sum_ed_abs=0, max_ed=0.
- Directed errors: 4 samples (255,255,p=65000), (3,5,p=15), (10,10,p=120), (0,7,p=1) -> err_count=3, sum_ed_abs=25+20+1=46, max_ed=25. With APPROX_MON_SIGNED_SUM_EN, sum_ed_signed=25-20-1=4.
- Handshake: num_samples=3, in_valid held high for 6 cycles -> exactly 3 acceptances, in_ready low from the cycle after the 3rd, done 3 cycles after the 3rd acceptance; start pulsed while busy is ignored.
- Zero-length run: start with num_samples=0 -> done pulses the cycle after start, all statistics 0, in_ready never asserts.
- Saturation: SUM_W forced small (CNT_W=4, SUM_W=8), num_samples=2 with |ED|=200 each -> sum_ed_abs=255, not 144.
